// File: rtl/fifo_lane_cnt.sv
// ---------------------------------------------------------------------------
// fifo_lane_cnt
//
// Counts the leading ones of a lane mask, starting from lane 0. Counting
// stops at the first zero lane, so only a contiguous run of requests from
// lane 0 upward is honoured. fifo_mw uses one instance for the push side
// and one for the pop side.
//
// Parameters:
//   LANES  number of lanes in the mask (1..4)
//   CW     width of the count, clog2(LANES+1)
//
// Ports:
//   lanes  in   LANES  request mask, lane 0 in bit 0
//   count  out  CW     number of contiguous ones from bit 0
// ---------------------------------------------------------------------------
module fifo_lane_cnt #(
  parameter int LANES = 2,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] lanes,
  output logic [CW-1:0]    count
);

  // A zero lane ends the run; any ones above it are ignored.
  always_comb begin
    logic stopped;
    count   = '0;
    stopped = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!stopped && lanes[i]) begin
        count = count + 1'b1;
      end else begin
        stopped = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_mw.sv
// ---------------------------------------------------------------------------
// fifo_mw
//
// Multi-lane synchronous FIFO. Up to LANES entries are pushed and up to LANES
// entries are popped every cycle, and strict FIFO order is kept across lanes.
// The output side is first-word-fall-through from registered storage: b_data
// is a combinational read of the storage registers at rd_ptr, rd_ptr+1, ...
// a_ready is derived from the registered level only, so there is no
// combinational path from the pop side to the push side.
//
// Parameters:
//   WIDTH     bits per entry
//   ABITS     log2 of depth (DEPTH = 1 << ABITS, DEPTH >= 2*LANES)
//   LANES     push/pop lanes per cycle (1..4)
//   AF_LEVEL  level at or above which a_almost_full asserts
//
// Ports:
//   clk            in   1            rising-edge clock
//   rst_n          in   1            asynchronous active-low reset
//   flush          in   1            synchronous clear of all entries
//   a_data         in   LANES*WIDTH  push data, lane i at [i*WIDTH +: WIDTH]
//   a_valid        in   LANES        push request per lane
//   a_ready        out  1            all LANES lanes can be accepted
//   a_almost_full  out  1            level >= AF_LEVEL
//   a_full         out  1            level == DEPTH
//   b_data         out  LANES*WIDTH  lane i = entry i positions after head
//   b_valid        out  LANES        lane i holds a valid entry
//   b_ready        in   LANES        pop acknowledge per lane
//   level          out  ABITS+1      current occupancy
// ---------------------------------------------------------------------------
module fifo_mw #(
  parameter int WIDTH    = 64,
  parameter int ABITS    = 3,
  parameter int LANES    = 2,
  parameter int AF_LEVEL = (1 << ABITS) - LANES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [LANES*WIDTH-1:0] a_data,
  input  logic [LANES-1:0]       a_valid,
  output logic                   a_ready,
  output logic                   a_almost_full,
  output logic                   a_full,
  output logic [LANES*WIDTH-1:0] b_data,
  output logic [LANES-1:0]       b_valid,
  input  logic [LANES-1:0]       b_ready,
  output logic [ABITS:0]         level
);

  localparam int DEPTH = 1 << ABITS;
  localparam int CW    = $clog2(LANES + 1);

  // Constants sized to the level register so all comparisons are same-width.
  localparam logic [ABITS:0] DEPTH_L = (ABITS + 1)'(DEPTH);
  localparam logic [ABITS:0] LANES_L = (ABITS + 1)'(LANES);
  localparam logic [ABITS:0] AF_L    = (ABITS + 1)'(AF_LEVEL);

  // Refuse to build an instance whose lane count or depth cannot work:
  // a full-width push must always fit when at most LANES entries remain.
  generate
    if (LANES < 1 || LANES > 4 || DEPTH < 2 * LANES) begin : g_bad_params
      $error("fifo_mw: illegal parameters (need LANES in 1..4 and DEPTH >= 2*LANES)");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   free_slots;
  logic [CW-1:0]    npush_raw;
  logic [CW-1:0]    npush;
  logic [CW-1:0]    npop;
  logic [LANES-1:0] pop_mask;

  // Status flags come straight from the registered level. A pop in the same
  // cycle deliberately does not raise a_ready; that keeps pop-side logic
  // off the push-side timing path at the cost of some throughput near full.
  assign free_slots    = DEPTH_L - level;
  assign a_ready       = (free_slots >= LANES_L);
  assign a_almost_full = (level >= AF_L);
  assign a_full        = (level == DEPTH_L);

  // Lane i is valid whenever at least i+1 entries are stored.
  always_comb begin
    b_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      b_valid[i] = (level > (ABITS + 1)'(i));
    end
  end

  // Head-relative read; the pointer addition wraps modulo DEPTH.
  always_comb begin
    b_data = '0;
    for (int i = 0; i < LANES; i++) begin
      b_data[i*WIDTH +: WIDTH] = mem[rd_ptr + ABITS'(i)];
    end
  end

  assign pop_mask = b_valid & b_ready;

  fifo_lane_cnt #(
    .LANES (LANES),
    .CW    (CW)
  ) u_push_cnt (
    .lanes (a_valid),
    .count (npush_raw)
  );

  fifo_lane_cnt #(
    .LANES (LANES),
    .CW    (CW)
  ) u_pop_cnt (
    .lanes (pop_mask),
    .count (npop)
  );

  // A push is all-or-nothing on a_ready, never a partial acceptance.
  assign npush = a_ready ? npush_raw : '0;

  // Storage has no reset; entries outside the valid window are don't-care.
  // Writes are suppressed under flush so dropped data never lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!flush && (CW'(i) < npush)) begin
        mem[wr_ptr + ABITS'(i)] <= a_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer and occupancy state. Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ABITS'(npush);
      rd_ptr <= rd_ptr + ABITS'(npop);
      level  <= level + (ABITS + 1)'(npush) - (ABITS + 1)'(npop);
    end
  end

endmodule

// File: tb/tb_fifo_mw.sv
// ---------------------------------------------------------------------------
// tb_fifo_mw
//
// Self-checking bench for fifo_mw with WIDTH=8, ABITS=2, LANES=2, AF_LEVEL=2.
// A queue holds the entries the FIFO should contain in order; accepted push
// lanes are appended when driven, and each visible output lane is compared
// against the queue, with popped lanes removed from the front.
// ---------------------------------------------------------------------------
module tb_fifo_mw;

  localparam int WIDTH = 8;
  localparam int ABITS = 2;
  localparam int LANES = 2;
  localparam int AF    = 2;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic [LANES*WIDTH-1:0] a_data;
  logic [LANES-1:0]       a_valid;
  logic                   a_ready;
  logic                   a_almost_full;
  logic                   a_full;
  logic [LANES*WIDTH-1:0] b_data;
  logic [LANES-1:0]       b_valid;
  logic [LANES-1:0]       b_ready;
  logic [ABITS:0]         level;

  logic [7:0] sb [$];
  int checks;
  int failures;

  fifo_mw #(
    .WIDTH    (WIDTH),
    .ABITS    (ABITS),
    .LANES    (LANES),
    .AF_LEVEL (AF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .a_data        (a_data),
    .a_valid       (a_valid),
    .a_ready       (a_ready),
    .a_almost_full (a_almost_full),
    .a_full        (a_full),
    .b_data        (b_data),
    .b_valid       (b_valid),
    .b_ready       (b_ready),
    .level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leading-ones count for a two-lane mask, written out case by case.
  function automatic int lead2(input logic [1:0] m);
    case (m)
      2'b11:   return 2;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle of stimulus, compare outputs against the model before
  // the edge, then advance the model to the post-edge state.
  task automatic applyStimulus(input logic [1:0] av, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] br, input logic fl);
    int   mlevel;
    logic mready;
    logic [1:0] mvalid;
    int   np;
    int   npop;
    @(negedge clk);
    a_valid = av;
    a_data  = {d1, d0};
    b_ready = br;
    flush   = fl;
    #1;
    mlevel = sb.size();
    mready = ((DEPTH - mlevel) >= LANES);
    mvalid = {mlevel > 1, mlevel > 0};
    np     = mready ? lead2(av) : 0;
    npop   = lead2(mvalid & br);
    checkOutput("level", 32'(level), 32'(mlevel));
    checkOutput("a_ready", 32'(a_ready), 32'(mready));
    checkOutput("a_full", 32'(a_full), 32'(mlevel == DEPTH));
    checkOutput("a_almost_full", 32'(a_almost_full), 32'(mlevel >= AF));
    checkOutput("b_valid", 32'(b_valid), 32'(mvalid));
    for (int i = 0; i < LANES; i++) begin
      if (i < mlevel) checkOutput($sformatf("b_data_lane%0d", i), 32'(b_data[i*WIDTH +: WIDTH]), 32'(sb[i]));
    end
    if (fl) begin
      sb.delete();
    end else begin
      for (int i = 0; i < npop; i++) void'(sb.pop_front());
      if (np > 0) sb.push_back(d0);
      if (np > 1) sb.push_back(d1);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    applyStimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    a_valid  = '0;
    a_data   = '0;
    b_ready  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_b_valid", 32'(b_valid), 32'd0);
    checkOutput("reset_a_ready", 32'(a_ready), 32'd1);
    checkOutput("reset_a_full", 32'(a_full), 32'd0);

    // Dual push, then observe lane order and almost-full.
    applyStimulus(2'b11, 8'h11, 8'h22, 2'b00, 1'b0);
    idle();
    checkOutput("dual_lane0", 32'(b_data[7:0]), 32'h11);
    checkOutput("dual_lane1", 32'(b_data[15:8]), 32'h22);
    checkOutput("dual_afull", 32'(a_almost_full), 32'd1);

    // Fill, then a rejected push while full.
    applyStimulus(2'b11, 8'h33, 8'h44, 2'b00, 1'b0);
    applyStimulus(2'b11, 8'h55, 8'h66, 2'b00, 1'b0);
    checkOutput("full_level", 32'(level), 32'd4);
    idle();

    // Full pop releases back-pressure.
    applyStimulus(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
    idle();
    checkOutput("after_pop_ready", 32'(a_ready), 32'd1);

    // Non-contiguous requests do nothing.
    applyStimulus(2'b10, 8'h77, 8'h88, 2'b00, 1'b0);
    applyStimulus(2'b00, 8'h00, 8'h00, 2'b10, 1'b0);
    idle();

    // Move the head to index 3 with two entries, then push 2 / pop 1.
    applyStimulus(2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
    applyStimulus(2'b01, 8'h99, 8'h00, 2'b00, 1'b0);
    applyStimulus(2'b11, 8'hAA, 8'hBB, 2'b01, 1'b0);
    idle();
    checkOutput("wrap_level", 32'(level), 32'd3);
    checkOutput("wrap_lane0", 32'(b_data[7:0]), 32'h99);
    checkOutput("wrap_lane1", 32'(b_data[15:8]), 32'hAA);

    // Flush beats concurrent push and pop; dropped data never resurfaces.
    applyStimulus(2'b11, 8'hCC, 8'hDD, 2'b11, 1'b1);
    idle();
    checkOutput("flush_b_valid", 32'(b_valid), 32'd0);
    applyStimulus(2'b11, 8'hEE, 8'hFF, 2'b00, 1'b0);
    idle();
    checkOutput("post_flush_lane0", 32'(b_data[7:0]), 32'hEE);

    // Asynchronous reset between edges with a push in flight.
    @(negedge clk);
    a_valid = 2'b11;
    a_data  = {8'h5A, 8'hA5};
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_level", 32'(level), 32'd0);
    checkOutput("async_b_valid", 32'(b_valid), 32'd0);
    checkOutput("async_a_ready", 32'(a_ready), 32'd1);
    checkOutput("async_a_full", 32'(a_full), 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    a_valid = 2'b00;
    rst_n   = 1'b1;
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      applyStimulus(2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
                    ($urandom_range(0, 15) == 0));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
